// File: rtl/hamming_sample_assembler.sv
// Hamming sample assembler: packs corrected 4-bit nibbles from the Hamming(7,4)
// decoder into PCM samples (MSB nibble first), presents them on a single-stage
// valid/ready holding register, and keeps saturating channel-quality statistics.
module hamming_sample_assembler #(
  parameter int SAMPLE_W = 16,
  parameter int STAT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              nib_valid,
  input  logic [3:0]                        nib_data,
  input  logic                              nib_error,
  input  logic                              nib_sof,
  input  logic                              stats_clr,
  output logic                              sample_valid,
  input  logic                              sample_ready,
  output logic [SAMPLE_W-1:0]               sample_data,
  output logic [$clog2(SAMPLE_W/4+1)-1:0]   sample_err,
  output logic [STAT_W-1:0]                 err_nib_cnt,
  output logic [STAT_W-1:0]                 drop_cnt,
  output logic [STAT_W-1:0]                 resync_cnt,
  output logic                              overrun
);

  localparam int NIBS  = SAMPLE_W / 4;
  localparam int IDX_W = $clog2(NIBS);
  localparam int ERR_W = $clog2(NIBS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  typedef enum logic {HUNT, FILL} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  // Only the earlier NIBS-1 nibbles need storing; the last one arrives live.
  logic [SAMPLE_W-5:0]   sr_reg, sr_next;
  logic [ERR_W-1:0]      tally_reg, tally_next;

  logic                  complete;
  logic                  resync;
  logic [SAMPLE_W-1:0]   comp_data;
  logic [ERR_W-1:0]      comp_err;

  logic                  valid_reg;
  logic [SAMPLE_W-1:0]   data_reg;
  logic [ERR_W-1:0]      err_reg;
  logic                  overrun_reg;
  logic                  drop;

  assign comp_data = {sr_reg, nib_data};
  assign comp_err  = tally_reg + ERR_W'(nib_error);

  // Assembler state, nibble index, shift register and per-sample error tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      idx_reg   <= '0;
      sr_reg    <= '0;
      tally_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sr_reg    <= sr_next;
      tally_reg <= tally_next;
    end
  end

  // Next-state logic: hunt for sof, then fill samples back to back; a sof in
  // the middle of a sample abandons the partial one and restarts from it.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    sr_next    = sr_reg;
    tally_next = tally_reg;
    complete   = 1'b0;
    resync     = 1'b0;
    case (state_reg)
      HUNT: begin
        if (nib_valid && nib_sof) begin
          state_next = FILL;
          idx_next   = IDX_W'(1);
          sr_next    = (SAMPLE_W-4)'(nib_data);
          tally_next = ERR_W'(nib_error);
        end
      end
      FILL: begin
        if (nib_valid) begin
          if (nib_sof && idx_reg != '0) begin
            resync     = 1'b1;
            idx_next   = IDX_W'(1);
            sr_next    = (SAMPLE_W-4)'(nib_data);
            tally_next = ERR_W'(nib_error);
          end else begin
            sr_next    = comp_data[SAMPLE_W-5:0];
            tally_next = (idx_reg == '0) ? ERR_W'(nib_error) : comp_err;
            if (idx_reg == LAST_IDX) begin
              complete = 1'b1;
              idx_next = '0;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // A completion is dropped only when the holding stage is full and not draining.
  assign drop = complete && valid_reg && !sample_ready;

  // Single holding stage toward the sink; reloads in the handshake cycle for full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      err_reg   <= '0;
    end else if (complete && (!valid_reg || sample_ready)) begin
      valid_reg <= 1'b1;
      data_reg  <= comp_data;
      err_reg   <= comp_err;
    end else if (valid_reg && sample_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Saturating statistics counters: 0 = corrected nibbles, 1 = drops, 2 = resyncs.
  logic [2:0]        stat_inc;
  logic [STAT_W-1:0] stat_reg [3];

  assign stat_inc = {resync, drop, nib_valid && nib_error};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      // Clear wins over a same-cycle increment; hold at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stat_reg[gi] <= '0;
        end else if (stats_clr) begin
          stat_reg[gi] <= '0;
        end else if (stat_inc[gi] && (stat_reg[gi] != {STAT_W{1'b1}})) begin
          stat_reg[gi] <= stat_reg[gi] + STAT_W'(1);
        end
      end
    end
  endgenerate

  // Sticky overrun flag, cleared only by reset or stats_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (stats_clr) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end
  end

  assign sample_valid = valid_reg;
  assign sample_data  = data_reg;
  assign sample_err   = err_reg;
  assign err_nib_cnt  = stat_reg[0];
  assign drop_cnt     = stat_reg[1];
  assign resync_cnt   = stat_reg[2];
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_hamming_sample_assembler.sv
// Directed testbench for hamming_sample_assembler (SAMPLE_W=16, STAT_W=16).
module tb_hamming_sample_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nib_valid = 1'b0;
  logic [3:0]  nib_data = 4'h0;
  logic        nib_error = 1'b0;
  logic        nib_sof = 1'b0;
  logic        stats_clr = 1'b0;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [15:0] sample_data;
  logic [2:0]  sample_err;
  logic [15:0] err_nib_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] resync_cnt;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] hs_q[$];
  int          hs_cyc[$];

  hamming_sample_assembler #(.SAMPLE_W(16), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .nib_valid(nib_valid), .nib_data(nib_data), .nib_error(nib_error), .nib_sof(nib_sof),
    .stats_clr(stats_clr),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_err(sample_err),
    .err_nib_cnt(err_nib_cnt), .drop_cnt(drop_cnt), .resync_cnt(resync_cnt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle; the transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      hs_q.push_back(sample_data);
      hs_cyc.push_back(cyc);
      $display("[%0t] handshake data=%h err=%0d", $time, sample_data, sample_err);
    end
  end

  task automatic drive_nib(input logic [3:0] d, input logic sof, input logic err);
    nib_valid = 1'b1;
    nib_data  = d;
    nib_sof   = sof;
    nib_error = err;
    @(posedge clk); #1;
    nib_valid = 1'b0;
    nib_sof   = 1'b0;
    nib_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    checks++; if (sample_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", sample_data); end
    checks++; if (sample_err !== 3'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", sample_err); end
    checks++; if (err_nib_cnt !== 16'd0 || drop_cnt !== 16'd0 || resync_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", err_nib_cnt, drop_cnt, resync_cnt); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    idle(1);
    $display("test_reset done");
  endtask

  task automatic test_hunt();
    int base;
    base = hs_q.size();
    sample_ready = 1'b1;
    drive_nib(4'h1, 1'b0, 1'b0);
    drive_nib(4'h2, 1'b0, 1'b1);
    drive_nib(4'h3, 1'b0, 1'b0);
    drive_nib(4'h4, 1'b0, 1'b0);
    drive_nib(4'h5, 1'b0, 1'b0);
    drive_nib(4'h6, 1'b0, 1'b0);
    idle(2);
    checks++; if (hs_q.size() !== base) begin failures++; $display("FAIL hunt_no_output: got %0d samples expected 0", hs_q.size() - base); end
    checks++; if (err_nib_cnt !== 16'd1) begin failures++; $display("FAIL hunt_err_cnt: got %0d expected 1", err_nib_cnt); end
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    checks++; if (err_nib_cnt !== 16'd0) begin failures++; $display("FAIL hunt_clr: got %0d expected 0", err_nib_cnt); end
    $display("test_hunt done");
  endtask

  task automatic test_basic_pack();
    sample_ready = 1'b1;
    drive_nib(4'hA, 1'b1, 1'b0);
    drive_nib(4'hB, 1'b0, 1'b0);
    drive_nib(4'hC, 1'b0, 1'b0);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", sample_valid); end
    drive_nib(4'hD, 1'b0, 1'b0);
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", sample_valid); end
    checks++; if (sample_data !== 16'hABCD) begin failures++; $display("FAIL basic_data: got %h expected abcd", sample_data); end
    checks++; if (sample_err !== 3'd0) begin failures++; $display("FAIL basic_err: got %0d expected 0", sample_err); end
    idle(1);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid: got %b expected 0", sample_valid); end
    $display("test_basic_pack done");
  endtask

  task automatic test_error_tally();
    drive_nib(4'h1, 1'b1, 1'b1);
    drive_nib(4'h2, 1'b0, 1'b0);
    drive_nib(4'h3, 1'b0, 1'b0);
    drive_nib(4'h4, 1'b0, 1'b1);
    checks++; if (sample_data !== 16'h1234) begin failures++; $display("FAIL tally_data: got %h expected 1234", sample_data); end
    checks++; if (sample_err !== 3'd2) begin failures++; $display("FAIL tally_err: got %0d expected 2", sample_err); end
    checks++; if (err_nib_cnt !== 16'd2) begin failures++; $display("FAIL tally_err_cnt: got %0d expected 2", err_nib_cnt); end
    idle(1);
    $display("test_error_tally done");
  endtask

  task automatic test_backpressure();
    int base;
    sample_ready = 1'b0;
    drive_nib(4'h1, 1'b1, 1'b0);
    drive_nib(4'h1, 1'b0, 1'b0);
    drive_nib(4'h1, 1'b0, 1'b0);
    drive_nib(4'h1, 1'b0, 1'b0);
    drive_nib(4'h2, 1'b0, 1'b0);
    drive_nib(4'h2, 1'b0, 1'b0);
    drive_nib(4'h2, 1'b0, 1'b0);
    drive_nib(4'h2, 1'b0, 1'b0);
    idle(2);
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", sample_valid); end
    checks++; if (sample_data !== 16'h1111) begin failures++; $display("FAIL bp_data: got %h expected 1111", sample_data); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL bp_drop_cnt: got %0d expected 1", drop_cnt); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
    base = hs_q.size();
    sample_ready = 1'b1;
    idle(1);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs_valid: got %b expected 0", sample_valid); end
    idle(2);
    checks++; if (hs_q.size() !== base + 1) begin failures++; $display("FAIL bp_hs_count: got %0d expected 1", hs_q.size() - base); end
    else begin
      checks++; if (hs_q[base] !== 16'h1111) begin failures++; $display("FAIL bp_hs_data: got %h expected 1111", hs_q[base]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_resync();
    int base;
    base = hs_q.size();
    sample_ready = 1'b1;
    drive_nib(4'h5, 1'b1, 1'b0);
    drive_nib(4'h6, 1'b0, 1'b0);
    drive_nib(4'h7, 1'b1, 1'b0);
    drive_nib(4'h8, 1'b0, 1'b0);
    drive_nib(4'h9, 1'b0, 1'b0);
    drive_nib(4'hA, 1'b0, 1'b0);
    idle(2);
    checks++; if (resync_cnt !== 16'd1) begin failures++; $display("FAIL resync_cnt: got %0d expected 1", resync_cnt); end
    checks++; if (hs_q.size() !== base + 1) begin failures++; $display("FAIL resync_hs_count: got %0d expected 1", hs_q.size() - base); end
    else begin
      checks++; if (hs_q[base] !== 16'h789A) begin failures++; $display("FAIL resync_data: got %h expected 789a", hs_q[base]); end
    end
    $display("test_resync done");
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] exp_d;
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    checks++; if (drop_cnt !== 16'd0 || overrun !== 1'b0 || resync_cnt !== 16'd0) begin
      failures++; $display("FAIL b2b_clr: got drop=%0d ovr=%b resync=%0d expected 0/0/0", drop_cnt, overrun, resync_cnt); end
    base = hs_q.size();
    sample_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        drive_nib(4'(k * 4 + j), (k == 0 && j == 0), 1'b0);
      end
    end
    idle(2);
    checks++; if (hs_q.size() !== base + 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", hs_q.size() - base); end
    else begin
      for (int k = 0; k < 8; k++) begin
        exp_d = {4'(k * 4), 4'(k * 4 + 1), 4'(k * 4 + 2), 4'(k * 4 + 3)};
        checks++; if (hs_q[base + k] !== exp_d) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, hs_q[base + k], exp_d); end
        if (k > 0) begin
          checks++; if (hs_cyc[base + k] - hs_cyc[base + k - 1] !== 4) begin
            failures++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 4", k, hs_cyc[base + k] - hs_cyc[base + k - 1]); end
        end
      end
    end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
    drive_nib(4'h3, 1'b1, 1'b1);
    checks++; if (err_nib_cnt !== 16'd1) begin failures++; $display("FAIL b2b_err_cnt: got %0d expected 1", err_nib_cnt); end
    stats_clr = 1'b1;
    drive_nib(4'h4, 1'b0, 1'b1);
    stats_clr = 1'b0;
    checks++; if (err_nib_cnt !== 16'd0) begin failures++; $display("FAIL clr_priority: got %0d expected 0", err_nib_cnt); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_sample();
    int base;
    sample_ready = 1'b0;
    drive_nib(4'hC, 1'b1, 1'b0);
    drive_nib(4'h0, 1'b0, 1'b0);
    drive_nib(4'hD, 1'b0, 1'b0);
    drive_nib(4'hE, 1'b0, 1'b0);
    drive_nib(4'h1, 1'b1, 1'b1);
    drive_nib(4'h2, 1'b0, 1'b0);
    checks++; if (sample_valid !== 1'b1 || err_nib_cnt !== 16'd1) begin
      failures++; $display("FAIL rst_pre: got valid=%b err_cnt=%0d expected 1/1", sample_valid, err_nib_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", sample_valid); end
    #4;
    rst_n = 1'b1;
    idle(1);
    checks++; if (err_nib_cnt !== 16'd0 || drop_cnt !== 16'd0 || resync_cnt !== 16'd0 || overrun !== 1'b0) begin
      failures++; $display("FAIL rst_counters: got %0d/%0d/%0d/%b expected 0/0/0/0", err_nib_cnt, drop_cnt, resync_cnt, overrun); end
    base = hs_q.size();
    sample_ready = 1'b1;
    drive_nib(4'hB, 1'b1, 1'b0);
    drive_nib(4'hE, 1'b0, 1'b0);
    drive_nib(4'hE, 1'b0, 1'b0);
    drive_nib(4'hF, 1'b0, 1'b0);
    idle(3);
    checks++; if (hs_q.size() !== base + 1) begin failures++; $display("FAIL rst_hs_count: got %0d expected 1", hs_q.size() - base); end
    else begin
      checks++; if (hs_q[base] !== 16'hBEEF) begin failures++; $display("FAIL rst_data: got %h expected beef", hs_q[base]); end
    end
    $display("test_reset_mid_sample done");
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_basic_pack();
    test_error_tally();
    test_backpressure();
    test_resync();
    test_back_to_back();
    test_reset_mid_sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
